// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and writeback source encoding for the
//                register-file write side.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;

    // Which producer owns the value currently on the p5 write port.
    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2,
        WB_DIV  = 2'd3
    } wb_src_t;

    // Only load and divide results retire a scoreboard entry.
    function automatic logic is_multicycle(input wb_src_t src);
        return (src == WB_LOAD) || (src == WB_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_scoreboard
//  Description : Per-register pending bits for in-flight load/divide results
//                and the decode stall derived from them.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int REG_W    = cpu_pkg::REG_W
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                mark_i,
    input  logic [REG_W-1:0]    mark_reg_i,
    input  logic                clear_i,
    input  logic [REG_W-1:0]    clear_reg_i,
    input  logic [REG_W-1:0]    p2_reg_a_i,
    input  logic [REG_W-1:0]    p2_reg_b_i,
    input  logic                p2_literal_b_i,
    input  logic [REG_W-1:0]    p2_dest_reg_i,
    output logic [NUM_REGS-1:0] pending_o,
    output logic                stall_o
);

    // Register 0 has no storage; it is tied to zero in the exported vector.
    logic [NUM_REGS-1:1] pending_q;
    logic [NUM_REGS-1:1] pending_d;

    // Next pending state: clear on load/div commit, then set on issue so a
    // same-edge set of the same register wins.
    always_comb begin
        pending_d = pending_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (clear_i && (clear_reg_i == REG_W'(r))) begin
                pending_d[r] = 1'b0;
            end
            if (mark_i && (mark_reg_i == REG_W'(r))) begin
                pending_d[r] = 1'b1;
            end
        end
    end

    // Pending vector storage; reset discards every outstanding entry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = {pending_q, 1'b0};

    // Hold decode while any source operand or the destination is in flight.
    always_comb begin
        stall_o = pending_o[p2_reg_a_i]
                | (!p2_literal_b_i && pending_o[p2_reg_b_i])
                | pending_o[p2_dest_reg_i];
    end

endmodule
`default_nettype wire

// File: rtl/cpu_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_writeback
//  Description : Merges ALU, load and divider results onto the single
//                register-file write port (ALU > load > divide) and keeps the
//                pending scoreboard that stalls decode on in-flight results.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_writeback
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int REG_W    = cpu_pkg::REG_W,
    parameter int DATA_W   = cpu_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [REG_W-1:0]  p2_reg_a,
    input  logic [REG_W-1:0]  p2_reg_b,
    input  logic              p2_literal_b,
    input  logic [REG_W-1:0]  p2_dest_reg,
    output logic              p2_stall,
    input  logic              p3_mark,
    input  logic [REG_W-1:0]  p3_mark_reg,
    input  logic              p4_alu_valid,
    input  logic [REG_W-1:0]  p4_alu_dest,
    input  logic [DATA_W-1:0] p4_alu_result,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [REG_W-1:0]  ld_dest,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic [REG_W-1:0]  div_dest,
    input  logic [DATA_W-1:0] div_result,
    output logic [REG_W-1:0]  p5_dest_reg,
    output logic [DATA_W-1:0] p5_result
);

    logic [REG_W-1:0]    p5_dest_q,   p5_dest_d;
    logic [DATA_W-1:0]   p5_result_q, p5_result_d;
    wb_src_t             src_q,       src_d;

    wb_src_t             win_src;
    logic [REG_W-1:0]    win_dest;
    logic [DATA_W-1:0]   win_data;
    logic [NUM_REGS-1:0] pending;

    // Fixed-priority arbiter: the ALU cannot be back-pressured, so load and
    // divide only transfer in cycles the ALU leaves free.
    always_comb begin
        ld_ready  = !p4_alu_valid;
        div_ready = !p4_alu_valid && !ld_valid;
        win_src   = WB_NONE;
        win_dest  = '0;
        win_data  = p5_result_q;
        if (p4_alu_valid) begin
            win_src  = WB_ALU;
            win_dest = p4_alu_dest;
            win_data = p4_alu_result;
        end else if (ld_valid) begin
            win_src  = WB_LOAD;
            win_dest = ld_dest;
            win_data = ld_data;
        end else if (div_valid) begin
            win_src  = WB_DIV;
            win_dest = div_dest;
            win_data = div_result;
        end
    end

    // A winner targeting register 0 is consumed but never written; the data
    // register holds its old value whenever there is no write.
    always_comb begin
        src_d       = WB_NONE;
        p5_dest_d   = '0;
        p5_result_d = p5_result_q;
        if (win_src != WB_NONE && win_dest != '0) begin
            src_d       = win_src;
            p5_dest_d   = win_dest;
            p5_result_d = win_data;
        end
    end

    // Write-port register; the source tag travels with it to retire pending.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            p5_dest_q   <= '0;
            p5_result_q <= '0;
            src_q       <= WB_NONE;
        end else begin
            p5_dest_q   <= p5_dest_d;
            p5_result_q <= p5_result_d;
            src_q       <= src_d;
        end
    end

    assign p5_dest_reg = p5_dest_q;
    assign p5_result   = p5_result_q;

    // The pending bit clears on the same edge the regfile RAM commits, so
    // decode sees fresh data the first cycle the stall drops.
    cpu_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_W    (REG_W)
    ) u_scoreboard (
        .clock          (clock),
        .resetn         (resetn),
        .mark_i         (p3_mark),
        .mark_reg_i     (p3_mark_reg),
        .clear_i        (is_multicycle(src_q)),
        .clear_reg_i    (p5_dest_q),
        .p2_reg_a_i     (p2_reg_a),
        .p2_reg_b_i     (p2_reg_b),
        .p2_literal_b_i (p2_literal_b),
        .p2_dest_reg_i  (p2_dest_reg),
        .pending_o      (pending),
        .stall_o        (p2_stall)
    );

`ifndef SYNTHESIS
    // The WAW stall should make an ALU write to a pending register impossible.
    a_alu_not_pending: assert property (@(posedge clock) disable iff (!resetn)
        !(p4_alu_valid && pending[p4_alu_dest]));

    // Load/divide results must correspond to a previously marked register.
    a_ld_pending: assert property (@(posedge clock) disable iff (!resetn)
        (ld_valid && ld_ready && ld_dest != '0) |-> pending[ld_dest]);

    a_div_pending: assert property (@(posedge clock) disable iff (!resetn)
        (div_valid && div_ready && div_dest != '0) |-> pending[div_dest]);
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_writeback
//  Description : Self-checking bench for cpu_writeback: directed corner
//                sequences, an arbitration vector table and a randomized run
//                against a behavioural scoreboard model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_writeback;

    logic        clock = 1'b0;
    logic        resetn;
    logic [4:0]  p2_reg_a, p2_reg_b, p2_dest_reg;
    logic        p2_literal_b;
    logic        p2_stall;
    logic        p3_mark;
    logic [4:0]  p3_mark_reg;
    logic        p4_alu_valid;
    logic [4:0]  p4_alu_dest;
    logic [31:0] p4_alu_result;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_dest;
    logic [31:0] ld_data;
    logic        div_valid, div_ready;
    logic [4:0]  div_dest;
    logic [31:0] div_result;
    logic [4:0]  p5_dest_reg;
    logic [31:0] p5_result;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cpu_writeback dut (
        .clock         (clock),
        .resetn        (resetn),
        .p2_reg_a      (p2_reg_a),
        .p2_reg_b      (p2_reg_b),
        .p2_literal_b  (p2_literal_b),
        .p2_dest_reg   (p2_dest_reg),
        .p2_stall      (p2_stall),
        .p3_mark       (p3_mark),
        .p3_mark_reg   (p3_mark_reg),
        .p4_alu_valid  (p4_alu_valid),
        .p4_alu_dest   (p4_alu_dest),
        .p4_alu_result (p4_alu_result),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_dest       (ld_dest),
        .ld_data       (ld_data),
        .div_valid     (div_valid),
        .div_ready     (div_ready),
        .div_dest      (div_dest),
        .div_result    (div_result),
        .p5_dest_reg   (p5_dest_reg),
        .p5_result     (p5_result)
    );

    typedef struct {
        logic        alu_v, ld_v, dv_v;
        logic [4:0]  alu_d, ld_d, dv_d;
        logic        exp_ldr, exp_dvr;
        logic [4:0]  exp_d;
        logic [31:0] exp_res;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic idle();
        p2_reg_a = 0; p2_reg_b = 0; p2_dest_reg = 0; p2_literal_b = 0;
        p3_mark = 0; p3_mark_reg = 0;
        p4_alu_valid = 0; p4_alu_dest = 0; p4_alu_result = 0;
        ld_valid = 0; ld_dest = 0; ld_data = 0;
        div_valid = 0; div_dest = 0; div_result = 0;
    endtask

    task automatic mark(input logic [4:0] r);
        p3_mark = 1; p3_mark_reg = r;
        tick();
        p3_mark = 0;
    endtask

    // Randomized run state: model pending bits and queues of issued ops.
    bit          pend[32];
    int          ldq[$];
    int          dvq[$];
    logic [4:0]  e_d, n_d;
    logic [31:0] e_data, n_data;
    bit          e_mc, n_mc, pm, acc_ld, acc_dv, exp_stall;
    logic [4:0]  pm_r;

    initial begin
        tbl[0] = '{0, 0, 0,  5'd0,  5'd0,  5'd0, 1, 1, 5'd0,  32'h0};
        tbl[1] = '{0, 0, 1,  5'd0,  5'd0,  5'd11, 1, 1, 5'd11, 32'h301};
        tbl[2] = '{0, 1, 0,  5'd0,  5'd12, 5'd0, 1, 0, 5'd12, 32'h202};
        tbl[3] = '{0, 1, 1,  5'd0,  5'd13, 5'd14, 1, 0, 5'd13, 32'h203};
        tbl[4] = '{1, 0, 0,  5'd20, 5'd0,  5'd0, 0, 0, 5'd20, 32'h104};
        tbl[5] = '{1, 0, 1,  5'd21, 5'd0,  5'd15, 0, 0, 5'd21, 32'h105};
        tbl[6] = '{1, 1, 0,  5'd22, 5'd16, 5'd0, 0, 0, 5'd22, 32'h106};
        tbl[7] = '{1, 1, 1,  5'd23, 5'd17, 5'd18, 0, 0, 5'd23, 32'h107};

        idle();
        resetn = 0;
        repeat (3) tick();
        resetn = 1;

        // Reset state
        p2_reg_a = 3; p2_reg_b = 7; p2_dest_reg = 9;
        mid();
        chk("reset_p5_dest", p5_dest_reg, 0);
        chk("reset_p5_result", p5_result, 0);
        chk("reset_stall", p2_stall, 0);
        chk("reset_ld_ready", ld_ready, 1);
        chk("reset_div_ready", div_ready, 1);
        tick();
        idle();

        // ALU only
        p4_alu_valid = 1; p4_alu_dest = 5; p4_alu_result = 32'h12345678;
        mid();
        chk("alu_ld_ready", ld_ready, 0);
        tick();
        p4_alu_valid = 0;
        chk("alu_p5_dest", p5_dest_reg, 5);
        chk("alu_p5_result", p5_result, 32'h12345678);
        p2_reg_a = 5; p2_dest_reg = 5;
        mid();
        chk("alu_no_pending", p2_stall, 0);
        tick();
        idle();

        // Load hazard
        p2_reg_a = 7;
        mark(7);
        mid();
        chk("ldhz_stall_marked", p2_stall, 1);
        tick();
        ld_valid = 1; ld_dest = 7; ld_data = 32'hDEADBEEF;
        mid();
        chk("ldhz_ld_ready", ld_ready, 1);
        chk("ldhz_stall_accept", p2_stall, 1);
        tick();
        ld_valid = 0;
        chk("ldhz_p5_dest", p5_dest_reg, 7);
        chk("ldhz_p5_result", p5_result, 32'hDEADBEEF);
        mid();
        chk("ldhz_stall_commit", p2_stall, 1);
        tick();
        mid();
        chk("ldhz_stall_clear", p2_stall, 0);
        tick();
        idle();

        // Collision of all three sources
        mark(4);
        mark(6);
        p4_alu_valid = 1; p4_alu_dest = 2; p4_alu_result = 1;
        ld_valid = 1; ld_dest = 4; ld_data = 2;
        div_valid = 1; div_dest = 6; div_result = 3;
        mid();
        chk("col_ld_ready_c0", ld_ready, 0);
        chk("col_div_ready_c0", div_ready, 0);
        tick();
        p4_alu_valid = 0;
        chk("col_p5_c1_dest", p5_dest_reg, 2);
        chk("col_p5_c1_res", p5_result, 1);
        mid();
        chk("col_ld_ready_c1", ld_ready, 1);
        chk("col_div_ready_c1", div_ready, 0);
        tick();
        ld_valid = 0;
        chk("col_p5_c2_dest", p5_dest_reg, 4);
        chk("col_p5_c2_res", p5_result, 2);
        mid();
        chk("col_div_ready_c2", div_ready, 1);
        tick();
        div_valid = 0;
        chk("col_p5_c3_dest", p5_dest_reg, 6);
        chk("col_p5_c3_res", p5_result, 3);
        tick();
        chk("col_p5_c4_idle", p5_dest_reg, 0);
        idle();

        // Literal operand and WAW check
        mark(9);
        p2_reg_a = 0; p2_reg_b = 9; p2_literal_b = 1; p2_dest_reg = 0;
        mid();
        chk("lit_no_stall", p2_stall, 0);
        p2_literal_b = 0;
        #1;
        chk("regb_stall", p2_stall, 1);
        p2_literal_b = 1; p2_dest_reg = 9;
        #1;
        chk("waw_stall", p2_stall, 1);
        tick();
        idle();

        // Same-edge set/clear race on r8
        mark(8);
        ld_valid = 1; ld_dest = 8; ld_data = 32'h0000A5A5;
        tick();
        ld_valid = 0;
        p3_mark = 1; p3_mark_reg = 8;
        chk("race_p5_dest", p5_dest_reg, 8);
        tick();
        p3_mark = 0;
        p2_reg_a = 8;
        mid();
        chk("race_set_wins", p2_stall, 1);
        tick();
        mid();
        chk("race_still_pending", p2_stall, 1);
        tick();
        ld_valid = 1; ld_dest = 8; ld_data = 32'h0000005A;
        tick();
        ld_valid = 0;
        tick();
        mid();
        chk("race_second_clear", p2_stall, 0);
        tick();
        idle();

        // Register 0: mark and ALU write are both ignored
        p3_mark = 1; p3_mark_reg = 0;
        p4_alu_valid = 1; p4_alu_dest = 0; p4_alu_result = 32'hFFFF0000;
        tick();
        idle();
        chk("r0_no_write", p5_dest_reg, 0);
        mid();
        chk("r0_no_pending", p2_stall, 0);
        tick();

        // Arbitration vector table
        for (int r = 11; r <= 18; r++) mark(5'(r));
        for (int i = 0; i < 8; i++) begin
            p4_alu_valid = tbl[i].alu_v; p4_alu_dest = tbl[i].alu_d; p4_alu_result = 32'h100 + 32'(i);
            ld_valid = tbl[i].ld_v; ld_dest = tbl[i].ld_d; ld_data = 32'h200 + 32'(i);
            div_valid = tbl[i].dv_v; div_dest = tbl[i].dv_d; div_result = 32'h300 + 32'(i);
            mid();
            chk($sformatf("tbl%0d_ld_ready", i), ld_ready, tbl[i].exp_ldr);
            chk($sformatf("tbl%0d_div_ready", i), div_ready, tbl[i].exp_dvr);
            tick();
            p4_alu_valid = 0; ld_valid = 0; div_valid = 0;
            chk($sformatf("tbl%0d_p5_dest", i), p5_dest_reg, tbl[i].exp_d);
            if (tbl[i].exp_d != 0) chk($sformatf("tbl%0d_p5_res", i), p5_result, tbl[i].exp_res);
        end
        idle();

        // Asynchronous reset in the middle of traffic
        p3_mark = 1; p3_mark_reg = 3;
        p4_alu_valid = 1; p4_alu_dest = 5; p4_alu_result = 32'h77;
        tick();
        p3_mark = 0;
        p4_alu_dest = 6; p4_alu_result = 32'h88;
        p2_reg_a = 3;
        #2;
        chk("mrst_pre_stall", p2_stall, 1);
        chk("mrst_pre_p5", p5_dest_reg, 5);
        #1 resetn = 0;
        #1;
        chk("mrst_p5_dest", p5_dest_reg, 0);
        chk("mrst_p5_result", p5_result, 0);
        chk("mrst_stall", p2_stall, 0);
        tick();
        tick();
        idle();
        p2_reg_a = 3;
        resetn = 1;
        mid();
        chk("mrst_after_p5", p5_dest_reg, 0);
        chk("mrst_after_stall", p2_stall, 0);
        tick();
        idle();
        tick();

        // Randomized traffic against the behavioural model
        for (int i = 0; i < 32; i++) pend[i] = 0;
        e_d = 0; n_d = 0; e_data = 0; n_data = 0; e_mc = 0; n_mc = 0;
        pm = 0; pm_r = 0; acc_ld = 0; acc_dv = 0;
        for (int k = 0; k < 3000; k++) begin
            int r;
            // Account for the edge that just ended the previous cycle.
            if (e_mc && e_d != 0) pend[e_d] = 0;
            if (pm && pm_r != 0) begin
                pend[pm_r] = 1;
                if ($urandom_range(1, 0) == 1) ldq.push_back(int'(pm_r));
                else dvq.push_back(int'(pm_r));
            end
            e_d = n_d; e_data = n_data; e_mc = n_mc;
            chk("rnd_p5_dest", p5_dest_reg, e_d);
            if (e_d != 0) chk("rnd_p5_result", p5_result, e_data);
            if (acc_ld) ld_valid = 0;
            if (acc_dv) div_valid = 0;

            p4_alu_valid = 0;
            if ($urandom_range(99, 0) < 45) begin
                r = $urandom_range(31, 0);
                if (!pend[r]) begin
                    p4_alu_valid = 1; p4_alu_dest = 5'(r); p4_alu_result = $urandom;
                end
            end
            if (!ld_valid && ldq.size() > 0 && $urandom_range(99, 0) < 60) begin
                ld_valid = 1; ld_dest = 5'(ldq.pop_front()); ld_data = $urandom;
            end
            if (!div_valid && dvq.size() > 0 && $urandom_range(99, 0) < 60) begin
                div_valid = 1; div_dest = 5'(dvq.pop_front()); div_result = $urandom;
            end
            p3_mark = 0;
            if ($urandom_range(99, 0) < 30) begin
                r = $urandom_range(31, 0);
                if (r == 0 || !pend[r]) begin
                    p3_mark = 1; p3_mark_reg = 5'(r);
                end
            end
            p2_reg_a = 5'($urandom_range(31, 0));
            p2_reg_b = 5'($urandom_range(31, 0));
            p2_dest_reg = 5'($urandom_range(31, 0));
            p2_literal_b = 1'($urandom_range(1, 0));

            acc_ld = ld_valid && !p4_alu_valid;
            acc_dv = div_valid && !p4_alu_valid && !ld_valid;
            if (p4_alu_valid) begin
                n_d = p4_alu_dest; n_data = p4_alu_result; n_mc = 0;
            end else if (ld_valid) begin
                n_d = ld_dest; n_data = ld_data; n_mc = 1;
            end else if (div_valid) begin
                n_d = div_dest; n_data = div_result; n_mc = 1;
            end else begin
                n_d = 0; n_mc = 0;
            end
            if (n_d == 0) n_mc = 0;
            exp_stall = pend[p2_reg_a] | (!p2_literal_b && pend[p2_reg_b]) | pend[p2_dest_reg];
            pm = p3_mark; pm_r = p3_mark_reg;

            mid();
            chk("rnd_ld_ready", ld_ready, !p4_alu_valid);
            chk("rnd_div_ready", div_ready, !p4_alu_valid && !ld_valid);
            chk("rnd_stall", p2_stall, exp_stall);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
